// File: rtl/mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter
//
// Two-requester arbiter that owns the select of a shared WIDTH-bit 2-to-1
// mux (X/Y -> M). One source is granted at a time. A grant is protected
// against preemption for HOLD_CYCLES cycles. Contention is resolved
// round-robin. The muxed result is registered together with a valid flag.
//
// Ports
//   Clock  in   1      system clock, all state on the rising edge
//   Reset  in   1      synchronous, active-high reset
//   ReqX   in   1      source X requests the datapath (level)
//   ReqY   in   1      source Y requests the datapath (level)
//   X      in   WIDTH  source X data
//   Y      in   WIDTH  source Y data
//   GntX   out  1      X owns the datapath (decoded from registered state)
//   GntY   out  1      Y owns the datapath (decoded from registered state)
//   s      out  1      mux select, 0 = X, 1 = Y; keeps the last owner when idle
//   M      out  WIDTH  registered muxed data
//   Valid  out  1      M holds owner data
// ---------------------------------------------------------------------------
module mux_share_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqX,
    input  logic             ReqY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             GntX,
    output logic             GntY,
    output logic             s,
    output logic [WIDTH-1:0] M,
    output logic             Valid
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_X = 2'd1,
        ST_OWN_Y = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;   // last served source: 0 = X, 1 = Y
    logic             r_s;
    logic [WIDTH-1:0] r_m;
    logic             r_valid;
    logic             w_cnt_zero;
    logic             w_enter;

    assign w_cnt_zero = (r_cnt == '0);

    // A new tenure begins whenever the next state is an owning state that
    // differs from the current one; this covers IDLE->OWN and direct handover.
    assign w_enter = (w_next != r_state) && (w_next != ST_IDLE);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ReqX && ReqY) begin
                    // Round-robin: serve the source that was not served last.
                    w_next = r_last ? ST_OWN_X : ST_OWN_Y;
                end else if (ReqX) begin
                    w_next = ST_OWN_X;
                end else if (ReqY) begin
                    w_next = ST_OWN_Y;
                end
            end
            ST_OWN_X: begin
                if (!ReqX) begin
                    // Owner release is immediate, the hold only blocks preemption.
                    w_next = ReqY ? ST_OWN_Y : ST_IDLE;
                end else if (ReqY && w_cnt_zero) begin
                    w_next = ST_OWN_Y;
                end
            end
            ST_OWN_Y: begin
                if (!ReqY) begin
                    w_next = ReqX ? ST_OWN_X : ST_IDLE;
                end else if (ReqX && w_cnt_zero) begin
                    w_next = ST_OWN_X;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hold counter, round-robin pointer and mux select
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_last <= 1'b1;  // makes X win the first tie
            r_s    <= 1'b0;
        end else if (w_enter) begin
            r_cnt  <= LP_RELOAD;
            r_last <= (w_next == ST_OWN_Y);
            r_s    <= (w_next == ST_OWN_Y);
        end else if ((r_state != ST_IDLE) && !w_cnt_zero) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // Registered datapath: samples the live source of the current owner
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_m     <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_OWN_X: r_m <= X;
                ST_OWN_Y: r_m <= Y;
                default:  r_m <= '0;
            endcase
            r_valid <= (r_state != ST_IDLE);
        end
    end

    assign GntX  = (r_state == ST_OWN_X);
    assign GntY  = (r_state == ST_OWN_Y);
    assign s     = r_s;
    assign M     = r_m;
    assign Valid = r_valid;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_share_arbiter
//
// Directed bench for mux_share_arbiter. The main instance uses the default
// HOLD_CYCLES=8; a second instance with HOLD_CYCLES=1 shares the same inputs
// and is checked while both sources contend.
// ---------------------------------------------------------------------------
module tb_mux_share_arbiter;

    logic       Clock;
    logic       Reset;
    logic       ReqX;
    logic       ReqY;
    logic [3:0] X;
    logic [3:0] Y;
    logic       GntX, GntY, s, Valid;
    logic [3:0] M;
    logic       GntX1, GntY1, s1, Valid1;
    logic [3:0] M1;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ReqX  (ReqX),
        .ReqY  (ReqY),
        .X     (X),
        .Y     (Y),
        .GntX  (GntX),
        .GntY  (GntY),
        .s     (s),
        .M     (M),
        .Valid (Valid)
    );

    mux_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .ReqX  (ReqX),
        .ReqY  (ReqY),
        .X     (X),
        .Y     (Y),
        .GntX  (GntX1),
        .GntY  (GntY1),
        .s     (s1),
        .M     (M1),
        .Valid (Valid1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic gx, input logic gy,
                           input logic ss, input logic [3:0] m, input logic v);
        chk({tag, "_gntx"},  {7'd0, GntX},  {7'd0, gx});
        chk({tag, "_gnty"},  {7'd0, GntY},  {7'd0, gy});
        chk({tag, "_s"},     {7'd0, s},     {7'd0, ss});
        chk({tag, "_m"},     {4'd0, M},     {4'd0, m});
        chk({tag, "_valid"}, {7'd0, Valid}, {7'd0, v});
    endtask

    initial begin
        logic       own_y;
        logic       prev_y;
        logic [3:0] exp_m;

        Reset = 1'b1; ReqX = 1'b0; ReqY = 1'b0; X = 4'h0; Y = 4'h0;
        tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Idle for 5 cycles
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        end

        // Single X request
        ReqX = 1'b1; X = 4'hA;
        tick();
        chk_all("x_c1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("x_c2", 1'b1, 1'b0, 1'b0, 4'hA, 1'b1);
        X = 4'h3;
        tick();
        chk_all("x_live", 1'b1, 1'b0, 1'b0, 4'h3, 1'b1);
        ReqX = 1'b0;
        tick();
        chk_all("x_rel", 1'b0, 1'b0, 1'b0, 4'h3, 1'b1);
        tick();
        chk_all("x_idle", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Contention from a fresh reset: 8-cycle alternating tenures
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqX = 1'b1; ReqY = 1'b1; X = 4'h1; Y = 4'h2;
        for (int i = 1; i <= 32; i++) begin
            tick();
            own_y  = (((i - 1) / 8) % 2) == 1;
            prev_y = (((i - 2) / 8) % 2) == 1;
            exp_m  = (i == 1) ? 4'h0 : (prev_y ? 4'h2 : 4'h1);
            chk_all($sformatf("cont%0d", i), !own_y, own_y, own_y, exp_m, i >= 2);
            chk($sformatf("h1_cont%0d_gntx", i), {7'd0, GntX1}, {7'd0, (i % 2) == 1});
            chk($sformatf("h1_cont%0d_gnty", i), {7'd0, GntY1}, {7'd0, (i % 2) == 0});
        end

        // Preemption blocked: ReqY rises at tenure cycle 2
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqX = 1'b1; ReqY = 1'b0;
        tick();
        tick();
        chk("pre_c2_gntx", {7'd0, GntX}, 8'd1);
        ReqY = 1'b1;
        for (int c = 3; c <= 8; c++) begin
            tick();
            chk($sformatf("pre_c%0d_gntx", c), {7'd0, GntX}, 8'd1);
            chk($sformatf("pre_c%0d_gnty", c), {7'd0, GntY}, 8'd0);
        end
        tick();
        chk("pre_hand_gntx", {7'd0, GntX}, 8'd0);
        chk("pre_hand_gnty", {7'd0, GntY}, 8'd1);
        chk("pre_hand_s",    {7'd0, s},    8'd1);

        // Counter saturates at 0 under a long uncontended tenure
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqX = 1'b1; ReqY = 1'b0;
        for (int c = 1; c <= 12; c++) tick();
        chk("sat_c12_gntx", {7'd0, GntX}, 8'd1);
        ReqY = 1'b1;
        tick();
        chk("sat_hand_gnty", {7'd0, GntY}, 8'd1);

        // Early release at tenure cycle 3 with ReqY pending
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqX = 1'b1; ReqY = 1'b0; Y = 4'h5;
        tick();
        tick();
        tick();
        chk("early_c3_gntx", {7'd0, GntX}, 8'd1);
        ReqX = 1'b0; ReqY = 1'b1;
        tick();
        chk_all("early_hand", 1'b0, 1'b1, 1'b1, 4'h1, 1'b1);
        tick();
        chk_all("early_y", 1'b0, 1'b1, 1'b1, 4'h5, 1'b1);

        // Reset mid-tenure while Y owns with M=5
        Reset = 1'b1;
        tick();
        chk_all("rst_mid_y", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Reset mid-tenure while X owns; the next tie must still go to X
        Reset = 1'b0; ReqX = 1'b1; ReqY = 1'b0;
        tick();
        tick();
        chk("rst_x_own", {7'd0, GntX}, 8'd1);
        Reset = 1'b1; ReqY = 1'b1;
        tick();
        chk_all("rst_mid_x", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        Reset = 1'b0;
        tick();
        chk("tie_after_rst_gntx", {7'd0, GntX}, 8'd1);
        chk("tie_after_rst_gnty", {7'd0, GntY}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
